// File: rtl/axi4l_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes, FSM states
// and the fixed strobe width.
package axi4l_pkg;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } slave_state_e;

  function automatic resp_t err_to_resp(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axi4l_hold_reg.sv
// Single-entry valid/ready holding register. The entry stays full until the
// owner releases it; avail/out_data also expose a same-cycle handshake.
module axi4l_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         rel,
  output logic         avail,
  output logic [W-1:0] out_data
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         take;

  always_comb begin
    in_ready = en && !full_q;
    take     = in_valid && in_ready;
    full_d   = full_q;
    data_d   = data_q;
    if (rel) full_d = 1'b0;
    if (take) begin
      full_d = 1'b1;
      data_d = in_data;
    end
    // Bypass lets the owner act on the entry in the cycle it is accepted.
    avail    = full_q || take;
    out_data = full_q ? data_q : in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite slave that turns one AXI access at a time into a single-beat
// register bus request, with write-over-read priority and an ack timeout.
module axi4l_reg_slave
  import axi4l_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  reg_req,
  output logic                  reg_wr,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [3:0]            reg_wstrb,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack,
  input  logic                  reg_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  slave_state_e                  state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          awake_q;
  logic                          reg_req_q, reg_req_d;
  logic                          reg_wr_q, reg_wr_d;
  logic [ADDR_WIDTH-1:0]         reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]         reg_wdata_q, reg_wdata_d;
  logic [STRB_W-1:0]             reg_wstrb_q, reg_wstrb_d;
  resp_t                         resp_q, resp_d;
  logic [DATA_WIDTH-1:0]         rdata_q, rdata_d;
  logic                          bvalid_q, bvalid_d;
  logic                          rvalid_q, rvalid_d;

  logic                          idle, write_go, read_go, ack_ok, b_hs, r_hs;
  logic                          aw_avail, w_avail;
  logic [ADDR_WIDTH-1:0]         aw_addr;
  logic [DATA_WIDTH+STRB_W-1:0]  w_word;

  axi4l_hold_reg #(.W(ADDR_WIDTH)) u_aw_hold (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .en       (idle),
    .in_valid (AWVALID),
    .in_ready (AWREADY),
    .in_data  (AWADDR),
    .rel      (b_hs),
    .avail    (aw_avail),
    .out_data (aw_addr)
  );

  axi4l_hold_reg #(.W(DATA_WIDTH + STRB_W)) u_w_hold (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .en       (idle),
    .in_valid (WVALID),
    .in_ready (WREADY),
    .in_data  ({WDATA, WSTRB}),
    .rel      (b_hs),
    .avail    (w_avail),
    .out_data (w_word)
  );

  always_comb begin
    // awake_q keeps every READY low while reset is asserted.
    idle     = (state_q == IDLE) && awake_q;
    write_go = idle && aw_avail && w_avail;
    ARREADY  = idle && !write_go;
    read_go  = ARVALID && ARREADY;
    ack_ok   = reg_req_q && reg_ack;
    b_hs     = bvalid_q && BREADY;
    r_hs     = rvalid_q && RREADY;

    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_req_d   = 1'b0;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wstrb_d = reg_wstrb_q;
    resp_d      = resp_q;
    rdata_d     = rdata_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (write_go) begin
          state_d     = ACCESS;
          reg_wr_d    = 1'b1;
          reg_addr_d  = aw_addr & ALIGN_MASK;
          reg_wdata_d = w_word[DATA_WIDTH+STRB_W-1:STRB_W];
          reg_wstrb_d = w_word[STRB_W-1:0];
        end else if (read_go) begin
          state_d     = ACCESS;
          reg_wr_d    = 1'b0;
          reg_addr_d  = ARADDR & ALIGN_MASK;
          reg_wdata_d = '0;
          reg_wstrb_d = '0;
        end
      end
      ACCESS: begin
        cnt_d     = cnt_q + 1'b1;
        reg_req_d = 1'b1;
        // An ack on the last counted cycle still takes precedence over timeout.
        if (ack_ok || cnt_q == CNT_LAST) begin
          state_d   = RESP;
          reg_req_d = 1'b0;
          bvalid_d  = reg_wr_q;
          rvalid_d  = !reg_wr_q;
          resp_d    = ack_ok ? err_to_resp(reg_err) : SLVERR;
          if (!reg_wr_q) rdata_d = ack_ok ? reg_rdata : '0;
        end
      end
      RESP: begin
        if (b_hs || r_hs) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      awake_q     <= 1'b0;
      reg_req_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
      resp_q      <= OKAY;
      rdata_q     <= '0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      awake_q     <= 1'b1;
      reg_req_q   <= reg_req_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wstrb_q <= reg_wstrb_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign BVALID    = bvalid_q;
  assign RVALID    = rvalid_q;
  assign BRESP     = resp_q;
  assign RRESP     = resp_q;
  assign RDATA     = rdata_q;
  assign reg_req   = reg_req_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wstrb = reg_wstrb_q;

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Directed bench for axi4l_reg_slave: write/read paths, ordering, priority,
// timeout, error-on-timeout, stray ack and mid-access reset.
module tb_axi4l_reg_slave;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID, RREADY;
  logic        reg_req, reg_wr;
  logic [31:0] reg_addr, reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata;
  logic        reg_ack, reg_err;

  int errors = 0;
  int checks = 0;

  axi4l_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .reg_err(reg_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!reg_req && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, reg_req}, 32'd1);
  endtask

  task automatic do_ack(input logic err);
    reg_ack = 1'b1;
    reg_err = err;
    cyc();
    reg_ack = 1'b0;
    reg_err = 1'b0;
  endtask

  task automatic b_handshake(input string tag);
    BREADY = 1'b1;
    cyc();
    BREADY = 1'b0;
    chk(tag, {31'd0, BVALID}, 32'd0);
  endtask

  task automatic r_handshake(input string tag);
    RREADY = 1'b1;
    cyc();
    RREADY = 1'b0;
    chk(tag, {31'd0, RVALID}, 32'd0);
  endtask

  initial begin
    int n;
    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    reg_rdata = '0; reg_ack = 1'b0; reg_err = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_awready", {31'd0, AWREADY}, 32'd0);
    chk("rst_wready",  {31'd0, WREADY},  32'd0);
    chk("rst_arready", {31'd0, ARREADY}, 32'd0);
    chk("rst_bvalid",  {31'd0, BVALID},  32'd0);
    chk("rst_rvalid",  {31'd0, RVALID},  32'd0);
    chk("rst_reg_req", {31'd0, reg_req}, 32'd0);
    chk("rst_reg_wr",  {31'd0, reg_wr},  32'd0);
    chk("rst_rdata",   RDATA, 32'd0);
    chk("rst_bresp",   {30'd0, BRESP}, 32'd0);
    ARESETN = 1'b1;
    cyc();

    // AW and W together
    AWADDR = 32'h10; AWVALID = 1'b1;
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    #1;
    chk("t1_awready", {31'd0, AWREADY}, 32'd1);
    chk("t1_wready",  {31'd0, WREADY},  32'd1);
    cyc();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t1_entry_noreq", {31'd0, reg_req}, 32'd0);
    wait_req("t1_req");
    chk("t1_reg_wr",    {31'd0, reg_wr}, 32'd1);
    chk("t1_reg_addr",  reg_addr, 32'h10);
    chk("t1_reg_wdata", reg_wdata, 32'hCAFEF00D);
    chk("t1_reg_wstrb", {28'd0, reg_wstrb}, 32'hF);
    do_ack(1'b0);
    chk("t1_bvalid", {31'd0, BVALID}, 32'd1);
    chk("t1_bresp",  {30'd0, BRESP}, 32'd0);
    chk("t1_req_drop", {31'd0, reg_req}, 32'd0);
    b_handshake("t1_bvalid_clr");
    chk("t1_idle_awready", {31'd0, AWREADY}, 32'd1);

    // W three cycles before AW
    WDATA = 32'h0BADBEEF; WSTRB = 4'h3; WVALID = 1'b1;
    cyc();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_no_req", {31'd0, reg_req}, 32'd0);
      chk("t2_wready_full", {31'd0, WREADY}, 32'd0);
      cyc();
    end
    AWADDR = 32'h24; AWVALID = 1'b1;
    #1;
    chk("t2_awready", {31'd0, AWREADY}, 32'd1);
    cyc();
    AWVALID = 1'b0;
    wait_req("t2_req");
    chk("t2_reg_addr",  reg_addr, 32'h24);
    chk("t2_reg_wstrb", {28'd0, reg_wstrb}, 32'h3);
    chk("t2_reg_wdata", reg_wdata, 32'h0BADBEEF);
    do_ack(1'b0);
    chk("t2_bvalid", {31'd0, BVALID}, 32'd1);
    chk("t2_bresp",  {30'd0, BRESP}, 32'd0);
    b_handshake("t2_bvalid_clr");

    // Read with RREADY held low for 5 cycles
    ARADDR = 32'h08; ARVALID = 1'b1;
    #1;
    chk("t3_arready", {31'd0, ARREADY}, 32'd1);
    cyc();
    ARVALID = 1'b0;
    wait_req("t3_req");
    chk("t3_reg_wr",    {31'd0, reg_wr}, 32'd0);
    chk("t3_reg_addr",  reg_addr, 32'h08);
    chk("t3_reg_wstrb", {28'd0, reg_wstrb}, 32'h0);
    reg_rdata = 32'h12345678;
    do_ack(1'b0);
    reg_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      chk("t3_rvalid_hold", {31'd0, RVALID}, 32'd1);
      chk("t3_rdata_hold",  RDATA, 32'h12345678);
      chk("t3_rresp",       {30'd0, RRESP}, 32'd0);
      cyc();
    end
    r_handshake("t3_rvalid_clr");
    chk("t3_idle_arready", {31'd0, ARREADY}, 32'd1);

    // Write ready and ARVALID together: write first
    AWADDR = 32'h30; AWVALID = 1'b1;
    WDATA = 32'h11112222; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h0F; ARVALID = 1'b1;
    #1;
    chk("t4_arready_blocked", {31'd0, ARREADY}, 32'd0);
    cyc();
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_req("t4_wr_req");
    chk("t4_wr_first", {31'd0, reg_wr}, 32'd1);
    chk("t4_wr_addr",  reg_addr, 32'h30);
    do_ack(1'b0);
    chk("t4_bvalid", {31'd0, BVALID}, 32'd1);
    chk("t4_no_rvalid", {31'd0, RVALID}, 32'd0);
    chk("t4_bresp", {30'd0, BRESP}, 32'd0);
    b_handshake("t4_bvalid_clr");
    chk("t4_arready_after", {31'd0, ARREADY}, 32'd1);
    cyc();
    ARVALID = 1'b0;
    wait_req("t4_rd_req");
    chk("t4_rd_wr",   {31'd0, reg_wr}, 32'd0);
    chk("t4_rd_addr", reg_addr, 32'h0C);
    reg_rdata = 32'h0000A5A5;
    do_ack(1'b0);
    chk("t4_rvalid", {31'd0, RVALID}, 32'd1);
    chk("t4_rdata",  RDATA, 32'h0000A5A5);
    chk("t4_rresp",  {30'd0, RRESP}, 32'd0);
    r_handshake("t4_rvalid_clr");

    // Timeout: no ack at all
    ARADDR = 32'h40; ARVALID = 1'b1;
    cyc();
    ARVALID = 1'b0;
    n = 1;
    while (!RVALID && n < 40) begin
      cyc();
      n++;
    end
    chk("t5_timeout_cycle", n, 32'd17);
    chk("t5_rresp",   {30'd0, RRESP}, 32'h2);
    chk("t5_rdata",   RDATA, 32'h0);
    chk("t5_req_off", {31'd0, reg_req}, 32'd0);
    r_handshake("t5_rvalid_clr");

    // Ack with error on the timeout cycle, then a stray ack
    ARADDR = 32'h44; ARVALID = 1'b1;
    cyc();
    ARVALID = 1'b0;
    repeat (15) cyc();
    reg_ack = 1'b1; reg_err = 1'b1; reg_rdata = 32'h00000077;
    cyc();
    reg_ack = 1'b0; reg_err = 1'b0;
    chk("t6_rvalid", {31'd0, RVALID}, 32'd1);
    chk("t6_rresp",  {30'd0, RRESP}, 32'h2);
    chk("t6_rdata_from_ack", RDATA, 32'h00000077);
    r_handshake("t6_rvalid_clr");
    reg_ack = 1'b1;
    cyc(); cyc();
    chk("t6_stray_req",    {31'd0, reg_req}, 32'd0);
    chk("t6_stray_bvalid", {31'd0, BVALID}, 32'd0);
    chk("t6_stray_rvalid", {31'd0, RVALID}, 32'd0);
    reg_ack = 1'b0;
    chk("t6_idle_arready", {31'd0, ARREADY}, 32'd1);

    // Reset during ACCESS
    AWADDR = 32'h50; AWVALID = 1'b1;
    WDATA = 32'h55555555; WSTRB = 4'hF; WVALID = 1'b1;
    cyc();
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_req("t7_req");
    ARESETN = 1'b0;
    #1;
    chk("t7_req_drop", {31'd0, reg_req}, 32'd0);
    chk("t7_bvalid",   {31'd0, BVALID}, 32'd0);
    chk("t7_rvalid",   {31'd0, RVALID}, 32'd0);
    chk("t7_awready",  {31'd0, AWREADY}, 32'd0);
    cyc();
    ARESETN = 1'b1;
    cyc();
    AWADDR = 32'h54; AWVALID = 1'b1;
    WDATA = 32'h66666666; WSTRB = 4'hC; WVALID = 1'b1;
    cyc();
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_req("t7_new_req");
    chk("t7_new_addr",  reg_addr, 32'h54);
    chk("t7_new_wdata", reg_wdata, 32'h66666666);
    chk("t7_new_wstrb", {28'd0, reg_wstrb}, 32'hC);
    do_ack(1'b0);
    chk("t7_new_bvalid", {31'd0, BVALID}, 32'd1);
    chk("t7_new_bresp",  {30'd0, BRESP}, 32'd0);
    b_handshake("t7_bvalid_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
